// File: rtl/ahb_master_wr_fifo.sv
// First-word-fall-through write buffer feeding the AHB master UI port.
// Flags and head data are decoded from registered state only.
module ahb_master_wr_fifo #(
  parameter int BUS_WDT   = 32,
  parameter int DEPTH     = 16,
  parameter int AE_THRESH = 1,
  parameter int AF_THRESH = 2
) (
  input  logic                       i_hclk,
  input  logic                       i_hreset,
  input  logic                       i_flush,
  input  logic                       i_wr_en,
  input  logic [BUS_WDT-1:0]         i_wr_data,
  output logic                       o_full,
  output logic                       o_almost_full,
  output logic [$clog2(DEPTH):0]     o_level,
  output logic                       o_overflow,
  output logic                       o_underflow,
  output logic [BUS_WDT-1:0]         o_xfer_data,
  output logic                       o_xfer_dav,
  output logic                       o_xfer_almost_empty,
  input  logic                       i_xfer_adv
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] AE_L    = LW'(AE_THRESH);
  localparam logic [LW-1:0] AF_L    = LW'(DEPTH - AF_THRESH);

  if (!(BUS_WDT == 32 || BUS_WDT == 64)) begin : g_bad_wdt
    $error("ahb_master_wr_fifo: BUS_WDT must be 32 or 64");
  end
  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("ahb_master_wr_fifo: DEPTH must be a power of 2 and at least 4");
  end
  if (AE_THRESH >= DEPTH || AF_THRESH >= DEPTH) begin : g_bad_thresh
    $error("ahb_master_wr_fifo: thresholds must be below DEPTH");
  end

  logic [BUS_WDT-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]      level_q, level_d;
  logic               overflow_q, overflow_d;
  logic               underflow_q, underflow_d;
  logic               full, dav, push_ok, pop_ok, mem_we;

  assign full    = (level_q == DEPTH_L);
  assign dav     = (level_q != '0);
  assign push_ok = i_wr_en & ~full;
  assign pop_ok  = i_xfer_adv & dav;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    mem_we      = 1'b0;
    if (i_flush) begin
      // Flush clears contents but keeps the sticky error flags.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      overflow_d  = overflow_q | (i_wr_en & full);
      underflow_d = underflow_q | (i_xfer_adv & ~dav);
      mem_we      = push_ok & ~i_hreset;
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_ok && !pop_ok)      level_d = level_q + 1'b1;
      else if (pop_ok && !push_ok) level_d = level_q - 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_hclk) begin
    if (i_hreset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // NOTE: the storage array has no reset; stale entries are never visible because the head is gated by dav.
  always_ff @(posedge i_hclk) begin
    if (mem_we) mem_q[wr_ptr_q] <= i_wr_data;
  end

  assign o_full              = full;
  assign o_almost_full       = (level_q >= AF_L);
  assign o_level             = level_q;
  assign o_overflow          = overflow_q;
  assign o_underflow         = underflow_q;
  assign o_xfer_dav          = dav;
  assign o_xfer_almost_empty = (level_q <= AE_L);
  assign o_xfer_data         = dav ? mem_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_ahb_master_wr_fifo.sv
// Randomized bench for ahb_master_wr_fifo against a queue-based reference model.
module tb_ahb_master_wr_fifo;

  localparam int BUS_WDT = 32;
  localparam int DEPTH   = 16;
  localparam int AE      = 1;
  localparam int AF      = 2;

  logic               i_hclk = 1'b0;
  logic               i_hreset = 1'b1;
  logic               i_flush = 1'b0;
  logic               i_wr_en = 1'b0;
  logic [BUS_WDT-1:0] i_wr_data = '0;
  logic               i_xfer_adv = 1'b0;
  logic               o_full, o_almost_full, o_overflow, o_underflow;
  logic [4:0]         o_level;
  logic [BUS_WDT-1:0] o_xfer_data;
  logic               o_xfer_dav, o_xfer_almost_empty;

  ahb_master_wr_fifo #(.BUS_WDT(BUS_WDT), .DEPTH(DEPTH), .AE_THRESH(AE), .AF_THRESH(AF)) dut (
    .i_hclk(i_hclk), .i_hreset(i_hreset), .i_flush(i_flush),
    .i_wr_en(i_wr_en), .i_wr_data(i_wr_data),
    .o_full(o_full), .o_almost_full(o_almost_full), .o_level(o_level),
    .o_overflow(o_overflow), .o_underflow(o_underflow),
    .o_xfer_data(o_xfer_data), .o_xfer_dav(o_xfer_dav),
    .o_xfer_almost_empty(o_xfer_almost_empty), .i_xfer_adv(i_xfer_adv)
  );

  always #5 i_hclk = ~i_hclk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [BUS_WDT-1:0] model_q[$];
  bit                 m_ovf = 1'b0;
  bit                 m_unf = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model applies the buffer rules directly to a queue of words.
  task automatic model_edge(input bit rst, input bit fl, input bit wr,
                            input logic [BUS_WDT-1:0] d, input bit adv);
    int n;
    n = model_q.size();
    if (rst) begin
      model_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (fl) begin
      model_q.delete();
    end else begin
      if (wr && n == DEPTH) m_ovf = 1'b1;
      if (adv && n == 0)    m_unf = 1'b1;
      if (adv && n > 0)     void'(model_q.pop_front());
      if (wr && n < DEPTH)  model_q.push_back(d);
    end
  endtask

  task automatic check_outputs();
    int n;
    n = model_q.size();
    check("level", 64'(o_level), 64'(n));
    check("dav", 64'(o_xfer_dav), 64'(n != 0));
    check("full", 64'(o_full), 64'(n == DEPTH));
    check("almost_full", 64'(o_almost_full), 64'(n >= DEPTH - AF));
    check("almost_empty", 64'(o_xfer_almost_empty), 64'(n <= AE));
    check("data", 64'(o_xfer_data), (n != 0) ? 64'(model_q[0]) : 64'd0);
    check("overflow", 64'(o_overflow), 64'(m_ovf));
    check("underflow", 64'(o_underflow), 64'(m_unf));
  endtask

  // One clock: drive inputs, take the edge, update the model, compare on the falling edge.
  task automatic cycle(input bit wr, input logic [BUS_WDT-1:0] d, input bit adv,
                       input bit fl, input bit rst);
    i_wr_en    = wr;
    i_wr_data  = d;
    i_xfer_adv = adv;
    i_flush    = fl;
    i_hreset   = rst;
    @(posedge i_hclk);
    model_edge(rst, fl, wr, d, adv);
    @(negedge i_hclk);
    check_outputs();
  endtask

  initial begin
    // Reset held with push and pop requests active.
    cycle(1'b1, 32'h1111_1111, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 32'h2222_2222, 1'b1, 1'b1, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("rst_level_const", 64'(o_level), 64'd0);
    check("rst_ae_const", 64'(o_xfer_almost_empty), 64'd1);

    // First-word fall-through and almost-empty threshold.
    cycle(1'b1, 32'hA5A5_0001, 1'b0, 1'b0, 1'b0);
    check("fwft_data_const", 64'(o_xfer_data), 64'hA5A5_0001);
    cycle(1'b1, 32'hA5A5_0002, 1'b0, 1'b0, 1'b0);
    check("ae_off_const", 64'(o_xfer_almost_empty), 64'd0);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Fill to full, overflow push, drain in order.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 32'(i), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'hDEAD, 1'b0, 1'b0, 1'b0);
    check("ovf_const", 64'(o_overflow), 64'd1);
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("no_unf_const", 64'(o_underflow), 64'd0);

    // Push+pop while full, then while empty.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'hBEEF, 1'b1, 1'b0, 1'b0);
    check("full_pp_level", 64'(o_level), 64'd15);
    for (int i = 0; i < DEPTH - 1; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 32'hCAFE, 1'b1, 1'b0, 1'b0);
    check("empty_pp_level", 64'(o_level), 64'd1);
    check("empty_pp_unf", 64'(o_underflow), 64'd1);

    // Interleaved traffic at level 3..5 wrapping the pointers several times.
    for (int i = 0; i < 120; i++) begin
      int n;
      bit wr, adv;
      n = model_q.size();
      wr  = (n < 4) ? 1'b1 : (n > 4) ? 1'b0 : 1'($urandom_range(0, 1));
      adv = (n > 4) ? 1'b1 : (n < 3) ? 1'b0 : 1'($urandom_range(0, 1));
      cycle(wr, $urandom, adv, 1'b0, 1'b0);
    end

    // Flush at level 7 with simultaneous push and pop.
    while (model_q.size() < 7) cycle(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
    while (model_q.size() > 7) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 32'h7777_7777, 1'b1, 1'b1, 1'b0);
    check("flush_data_const", 64'(o_xfer_data), 64'd0);

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 3000; i++) begin
      bit wr, adv, fl, rst;
      int bias;
      bias = (i / 500) % 3;
      wr  = ($urandom_range(0, 3) < 2 + bias - 1);
      adv = ($urandom_range(0, 3) < 2 - bias + 1);
      fl  = ($urandom_range(0, 99) == 0);
      rst = ($urandom_range(0, 499) == 0);
      cycle(wr, $urandom, adv, fl, rst);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
